// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg
//   Shared definitions for the phase sequencer and the control decoder:
//   phase bit indices, one-hot phase encodings, the sequencer state enum
//   and the default retired-instruction counter width.
package phase_sequencer_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PH_W      = 5;

  localparam int PH_P0 = 0;  // fetch
  localparam int PH_P1 = 1;  // decode / register read
  localparam int PH_P2 = 2;  // ALU
  localparam int PH_P3 = 3;  // memory
  localparam int PH_P4 = 4;  // write-back

  localparam logic [PH_W-1:0] PH_OH_NONE = 5'b00000;
  localparam logic [PH_W-1:0] PH_OH_P0   = 5'b00001;
  localparam logic [PH_W-1:0] PH_OH_P1   = 5'b00010;
  localparam logic [PH_W-1:0] PH_OH_P2   = 5'b00100;
  localparam logic [PH_W-1:0] PH_OH_P3   = 5'b01000;
  localparam logic [PH_W-1:0] PH_OH_P4   = 5'b10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/phase_wait_timer.sv
// phase_wait_timer
//   Counts P3 wait cycles while memory is not ready.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     inc        one more wait cycle spent in P3
//     clr        clear the count (leaving P3); has priority over inc
//     last_wait  the current wait cycle is the one that reaches P3_TIMEOUT
//   last_wait depends only on the stored count so the sequencer can use it
//   to decide between waiting and timing out without a combinational loop.
module phase_wait_timer #(
  parameter int P3_TIMEOUT = 255,
  parameter int WAIT_W     = $clog2(P3_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic last_wait
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(P3_TIMEOUT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_wait = (count_q == LAST_CNT);

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Multi-cycle phase sequencer for the 16-bit processor. Generates the
//   one-hot phase vector P0..P4, handles run / stop / single-step / halt,
//   stretches P3 until memory is ready (with a timeout into a sticky
//   memory-error halt) and counts retired instructions.
//   Ports:
//     clk, rst     system clock, synchronous active-high reset
//     exec_pulse   start/stop toggle (one cycle)
//     step_pulse   single-instruction request (one cycle)
//     halt         HLT decoded, examined in P4
//     mem_ready    memory access complete, examined in P3
//     phase        one-hot {P4,P3,P2,P1,P0}, zero when not executing
//     p0           phase[0] for the decoder
//     running      RUN or STEP
//     halted       HALTED
//     mem_err      sticky P3 timeout flag
//     instr_done   high during the final P4 cycle
//     instr_count  retired instructions, wrapping
//
//   state  | meaning
//   IDLE   | stopped, waiting for exec_pulse or step_pulse
//   RUN    | free-running instructions until a stop at a boundary
//   STEP   | one instruction, then back to IDLE
//   HALTED | HLT retired or memory timeout; only rst leaves
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int P3_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_pulse,
  input  logic             step_pulse,
  input  logic             halt,
  input  logic             mem_ready,
  output logic [4:0]       phase,
  output logic             p0,
  output logic             running,
  output logic             halted,
  output logic             mem_err,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             stop_req_q, stop_req_d;
  logic             mem_err_q, mem_err_d;
  logic             instr_done_q, instr_done_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic wait_inc;
  logic wait_clr;
  logic wait_last;

  phase_wait_timer #(
    .P3_TIMEOUT(P3_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .last_wait(wait_last)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    stop_req_d = stop_req_q;
    mem_err_d  = mem_err_q;
    cnt_d      = cnt_q;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = PH_OH_NONE;
        if (exec_pulse) begin
          state_d = RUN;
          phase_d = PH_OH_P0;
        end else if (step_pulse) begin
          state_d = STEP;
          phase_d = PH_OH_P0;
        end
      end

      RUN, STEP: begin
        // A stop request is only recorded here; it is acted on at P4.
        if (state_q == RUN && exec_pulse) begin
          stop_req_d = 1'b1;
        end

        case (phase_q)
          PH_OH_P0: phase_d = PH_OH_P1;
          PH_OH_P1: phase_d = PH_OH_P2;
          PH_OH_P2: phase_d = PH_OH_P3;
          PH_OH_P3: begin
            if (mem_ready) begin
              phase_d  = PH_OH_P4;
              wait_clr = 1'b1;
            end else if (wait_last) begin
              // Timed out: abandon the instruction without write-back.
              state_d   = HALTED;
              phase_d   = PH_OH_NONE;
              mem_err_d = 1'b1;
              wait_clr  = 1'b1;
            end else begin
              wait_inc = 1'b1;
            end
          end
          PH_OH_P4: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (halt) begin
              state_d    = HALTED;
              phase_d    = PH_OH_NONE;
              stop_req_d = 1'b0;
            end else if (state_q == STEP || stop_req_q) begin
              state_d    = IDLE;
              phase_d    = PH_OH_NONE;
              // An exec_pulse coinciding with the boundary stop is a new
              // toggle, so the request is re-armed rather than lost.
              stop_req_d = (state_q == RUN) && exec_pulse;
            end else begin
              phase_d = PH_OH_P0;
            end
          end
          default: begin
            state_d = IDLE;
            phase_d = PH_OH_NONE;
          end
        endcase
      end

      HALTED: begin
        phase_d = PH_OH_NONE;
      end

      default: begin
        state_d = IDLE;
        phase_d = PH_OH_NONE;
      end
    endcase

    // Outputs are registered from the next-state values so they line up
    // with the phase they describe.
    instr_done_d = (phase_d == PH_OH_P4);
    running_d    = (state_d == RUN) || (state_d == STEP);
    halted_d     = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= PH_OH_NONE;
      stop_req_q   <= 1'b0;
      mem_err_q    <= 1'b0;
      instr_done_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      stop_req_q   <= stop_req_d;
      mem_err_q    <= mem_err_d;
      instr_done_q <= instr_done_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
      cnt_q        <= cnt_d;
    end
  end

  assign phase       = phase_q;
  assign p0          = phase_q[PH_P0];
  assign running     = running_q;
  assign halted      = halted_q;
  assign mem_err     = mem_err_q;
  assign instr_done  = instr_done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
//   Each stimulus cycle pushes the values the outputs must show during that
//   cycle; a negedge monitor pops and compares them.
module tb_phase_sequencer;

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] P0 = 5'b00001;
  localparam logic [4:0] P1 = 5'b00010;
  localparam logic [4:0] P2 = 5'b00100;
  localparam logic [4:0] P3 = 5'b01000;
  localparam logic [4:0] P4 = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       exec_pulse = 1'b0;
  logic       step_pulse = 1'b0;
  logic       halt = 1'b0;
  logic       mem_ready = 1'b1;
  logic [4:0] phase;
  logic       p0;
  logic       running;
  logic       halted;
  logic       mem_err;
  logic       instr_done;
  logic [3:0] instr_count;

  always #5 clk = ~clk;

  phase_sequencer #(
    .CNT_W     (4),
    .P3_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exec_pulse (exec_pulse),
    .step_pulse (step_pulse),
    .halt       (halt),
    .mem_ready  (mem_ready),
    .phase      (phase),
    .p0         (p0),
    .running    (running),
    .halted     (halted),
    .mem_err    (mem_err),
    .instr_done (instr_done),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [4:0] ph;
    logic       dn;
    logic [3:0] cnt;
    logic       run;
    logic       hlt;
    logic       merr;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_cnt  = 4'd0;
  logic       exp_merr = 1'b0;
  int         n_chk    = 0;
  int         n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("phase",       32'(phase),       32'(e.ph));
      chk("p0",          32'(p0),          32'(e.ph[0]));
      chk("instr_done",  32'(instr_done),  32'(e.dn));
      chk("instr_count", 32'(instr_count), 32'(e.cnt));
      chk("running",     32'(running),     32'(e.run));
      chk("halted",      32'(halted),      32'(e.hlt));
      chk("mem_err",     32'(mem_err),     32'(e.merr));
    end
  end

  // One cycle: drive inputs (sampled at the next edge) and record what the
  // outputs must show during this cycle.
  task automatic cyc(input logic [4:0] ph, input logic dn, input logic run, input logic hlt,
                     input logic ex, input logic st, input logic hl, input logic mr);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    exec_pulse = ex;
    step_pulse = st;
    halt       = hl;
    mem_ready  = mr;
    e.ph   = ph;
    e.dn   = dn;
    e.cnt  = exp_cnt;
    e.run  = run;
    e.hlt  = hlt;
    e.merr = exp_merr;
    exp_q.push_back(e);
    if (dn) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic idle_c(input logic ex, input logic st);
    cyc(Z, 1'b0, 1'b0, 1'b0, ex, st, 1'b0, 1'b1);
  endtask

  task automatic halted_c(input logic ex, input logic st);
    cyc(Z, 1'b0, 1'b0, 1'b1, ex, st, 1'b0, 1'b1);
  endtask

  // One full instruction; step_pulse in P1 and mem_ready low in P1 must be ignored.
  task automatic instr(input int waits, input logic hl, input logic ex_p2, input logic ex_p4);
    cyc(P0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1);
    cyc(P1, 1'b0, 1'b1, 1'b0, 1'b0,  1'b1, hl,   1'b0);
    cyc(P2, 1'b0, 1'b1, 1'b0, ex_p2, 1'b0, hl,   1'b1);
    for (int i = 0; i < waits; i++) cyc(P3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, hl, 1'b0);
    cyc(P3, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, hl,   1'b1);
    cyc(P4, 1'b1, 1'b1, 1'b0, ex_p4, 1'b0, hl,   1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    exec_pulse = 1'b0;
    step_pulse = 1'b0;
    halt       = 1'b0;
    mem_ready  = 1'b0;
    exp_cnt    = 4'd0;
    exp_merr   = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    // Run: exec, plain instruction, then a stalled one with stop in P2.
    do_reset();
    idle_c(1'b0, 1'b0);
    idle_c(1'b1, 1'b0);
    instr(0, 1'b0, 1'b0, 1'b0);
    instr(3, 1'b0, 1'b1, 1'b0);
    idle_c(1'b0, 1'b0);
    idle_c(1'b0, 1'b0);

    // Single step; exec inside STEP ignored.
    idle_c(1'b0, 1'b1);
    instr(0, 1'b0, 1'b1, 1'b1);
    idle_c(1'b0, 1'b0);
    idle_c(1'b0, 1'b0);

    // exec and step together: exec wins, so a second instruction follows.
    idle_c(1'b1, 1'b1);
    instr(0, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b0, 1'b1, 1'b0);
    idle_c(1'b0, 1'b0);

    // exec in P4 without a pending stop: one more instruction, then stop.
    idle_c(1'b1, 1'b0);
    instr(0, 1'b0, 1'b0, 1'b1);
    instr(0, 1'b0, 1'b0, 1'b0);
    idle_c(1'b0, 1'b0);

    // exec at the stopping boundary: stays stopped.
    idle_c(1'b1, 1'b0);
    instr(0, 1'b0, 1'b1, 1'b1);
    idle_c(1'b0, 1'b0);
    idle_c(1'b0, 1'b0);

    // Counter wrap after 16 retired instructions.
    do_reset();
    idle_c(1'b0, 1'b0);
    idle_c(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) instr(k % 4, 1'b0, (k == 15), 1'b0);
    idle_c(1'b0, 1'b0);

    // Halt on the second instruction; pulses ignored while halted.
    do_reset();
    idle_c(1'b0, 1'b0);
    idle_c(1'b1, 1'b0);
    instr(0, 1'b0, 1'b0, 1'b0);
    instr(1, 1'b1, 1'b0, 1'b0);
    halted_c(1'b1, 1'b0);
    halted_c(1'b0, 1'b1);
    halted_c(1'b1, 1'b1);
    do_reset();
    idle_c(1'b0, 1'b0);

    // Halt in STEP mode.
    idle_c(1'b0, 1'b1);
    instr(0, 1'b1, 1'b0, 1'b0);
    halted_c(1'b0, 1'b0);

    // Halt and stop request in the same P4: halt wins.
    do_reset();
    idle_c(1'b1, 1'b0);
    instr(0, 1'b1, 1'b1, 1'b0);
    halted_c(1'b0, 1'b0);

    // P3 timeout: four wait cycles, then HALTED with mem_err, no instr_done.
    do_reset();
    idle_c(1'b1, 1'b0);
    cyc(P0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(P1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(P2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(P3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_merr = 1'b1;
    halted_c(1'b1, 1'b0);
    halted_c(1'b0, 1'b1);
    do_reset();
    idle_c(1'b0, 1'b0);

    // rst during P3 aborts; wait counter must restart from zero afterwards.
    idle_c(1'b1, 1'b0);
    cyc(P0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(P1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(P2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(P3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle_c(1'b0, 1'b0);
    idle_c(1'b1, 1'b0);
    instr(3, 1'b0, 1'b1, 1'b0);
    idle_c(1'b0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
